// File: rtl/motion_update_broadcaster.sv
// motion_update_broadcaster
// Accepts updated particles from the motion datapath and works out each
// particle's destination cell, wrapping periodically at the grid edges. It
// queues the entries and broadcasts one per cycle to every cell cache. The
// whole update is framed by out_motion_update_enable. A single done pulse
// follows once the caches have had time to swap their buffers.
module motion_update_broadcaster #(
  parameter int DATA_WIDTH      = 32,
  parameter int CELL_ID_WIDTH   = 4,
  parameter int X_DIM           = 4,
  parameter int Y_DIM           = 4,
  parameter int Z_DIM           = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [3*DATA_WIDTH-1:0]    in_data,
  input  logic [3*CELL_ID_WIDTH-1:0] in_src_cell,
  input  logic [5:0]                 in_cross,
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_busy,
  output logic                       out_done,
  output logic [COUNT_WIDTH-1:0]     out_particle_count,
  output logic                       out_error
);

  localparam int CW      = CELL_ID_WIDTH;
  localparam int AW      = FIFO_ADDR_WIDTH;
  localparam int ENTRY_W = 3*DATA_WIDTH + 3*CW;

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, SETTLE, DONE} state_t;

  state_t state_reg, state_next;
  logic   settle_cnt_reg;

  logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic               fifo_empty, fifo_full;
  logic               push, pop, start_accept;

  logic [3*CW-1:0]    dst_cell;
  logic [2:0]         axis_err;
  logic               push_err;

  logic [3*DATA_WIDTH-1:0] out_data_reg;
  logic [3*CW-1:0]         out_cell_reg;
  logic                    out_valid_reg;
  logic                    enable_reg;
  logic [COUNT_WIDTH-1:0]  count_reg;
  logic                    error_reg;

  // Extra pointer MSB tells full apart from empty when the indices match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign start_accept = (state_reg == IDLE) && in_start;
  assign in_ready     = (state_reg == STREAM) && !fifo_full;
  assign push         = in_valid && in_ready;
  assign pop          = ((state_reg == STREAM) || (state_reg == DRAIN)) && !fifo_empty;

  // Per-axis destination. Cell slice gi=0 is z, 1 is y, 2 is x. The cross
  // code for that axis sits at the mirrored position in in_cross.
  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    localparam int AXIS_DIM = (gi == 0) ? Z_DIM : ((gi == 1) ? Y_DIM : X_DIM);
    localparam logic [CW-1:0] DIM_C = CW'(AXIS_DIM);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] src_c;
    logic [1:0]    code;
    logic [CW-1:0] axis_dst;
    logic          axis_bad;

    assign src_c = in_src_cell[gi*CW +: CW];
    assign code  = in_cross[(2-gi)*2 +: 2];

    // Periodic wrap. Out-of-range coordinates and the illegal code pass
    // through unchanged and flag an error.
    always_comb begin
      axis_dst = src_c;
      axis_bad = 1'b0;
      if ((src_c == '0) || (src_c > DIM_C)) begin
        axis_bad = 1'b1;
      end else begin
        case (code)
          2'b01:   axis_dst = (src_c == DIM_C) ? ONE_C : src_c + ONE_C;
          2'b11:   axis_dst = (src_c == ONE_C) ? DIM_C : src_c - ONE_C;
          2'b10:   axis_bad = 1'b1;
          default: axis_dst = src_c;
        endcase
      end
    end

    assign dst_cell[gi*CW +: CW] = axis_dst;
    assign axis_err[gi]          = axis_bad;
  end

  assign push_err = |axis_err;

  // Broadcast buffer storage. The array has no reset, so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {in_data, dst_cell};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Registered broadcast. Payload and cell are zero whenever not valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg  <= '0;
      out_cell_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (pop) begin
      {out_data_reg, out_cell_reg} <= fifo_mem[rd_ptr_reg[AW-1:0]];
      out_valid_reg                <= 1'b1;
    end else begin
      out_data_reg  <= '0;
      out_cell_reg  <= '0;
      out_valid_reg <= 1'b0;
    end
  end

  // State register plus the settle-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= (state_reg == SETTLE) ? ~settle_cnt_reg : 1'b0;
    end
  end

  // Next-state logic. DRAIN ends only after the last broadcast has left.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_start) state_next = STREAM;
      STREAM:  if (push && in_last) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !out_valid_reg) state_next = SETTLE;
      SETTLE:  if (settle_cnt_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Enable frames the broadcast window. It falls on the edge that leaves DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_reg <= 1'b0;
    end else begin
      enable_reg <= (state_next == STREAM) || (state_next == DRAIN);
    end
  end

  // Saturating broadcast counter. It holds its value between updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (start_accept) begin
      count_reg <= '0;
    end else if (pop && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Sticky error flag for bad cross codes or bad source coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_reg <= 1'b0;
    end else if (start_accept) begin
      error_reg <= 1'b0;
    end else if (push && push_err) begin
      error_reg <= 1'b1;
    end
  end

  assign out_motion_update_enable = enable_reg;
  assign out_data                 = out_data_reg;
  assign out_data_dst_cell        = out_cell_reg;
  assign out_data_valid           = out_valid_reg;
  assign out_busy                 = (state_reg != IDLE);
  assign out_done                 = (state_reg == DONE);
  assign out_particle_count       = count_reg;
  assign out_error                = error_reg;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster. A reference model predicts every
// broadcast from the wrap rules using modular arithmetic. A per-cycle
// checker compares the DUT against it. Directed updates cover the listed
// scenarios, with literal expectations alongside.
module tb_motion_update_broadcaster;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [3*DW-1:0] in_data = '0;
  logic [3*CW-1:0] in_src_cell = '0;
  logic [5:0]      in_cross = '0;
  logic            enable;
  logic [3*DW-1:0] out_data;
  logic [3*CW-1:0] out_dst;
  logic            out_valid;
  logic            out_busy;
  logic            out_done;
  logic [CNTW-1:0] out_count;
  logic            out_error;

  motion_update_broadcaster #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .X_DIM(4), .Y_DIM(4), .Z_DIM(4),
    .FIFO_DEPTH(8), .FIFO_ADDR_WIDTH(3), .COUNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .in_src_cell(in_src_cell), .in_cross(in_cross),
    .out_motion_update_enable(enable), .out_data(out_data),
    .out_data_dst_cell(out_dst), .out_data_valid(out_valid),
    .out_busy(out_busy), .out_done(out_done),
    .out_particle_count(out_count), .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3*DW-1:0] d;
    logic [3*CW-1:0] c;
  } entry_t;

  entry_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     exp_cnt = 0;
  bit     exp_err = 1'b0;
  int     beats_seen = 0;
  int     done_cnt = 0;
  int     stall_cnt = 0;
  int     last_en_high_cyc = 0;
  int     last_valid_cyc = 0;
  bit     prev_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Destination from the wrap rules: (c-1+delta) mod DIM, then +1.
  function automatic void model_dst(input logic [11:0] src, input logic [5:0] cr,
                                    output logic [11:0] dst, output bit err);
    int c;
    int code;
    int delta;
    int res;
    err = 1'b0;
    dst = '0;
    for (int a = 0; a < 3; a++) begin
      c     = int'(src[(2-a)*4 +: 4]);
      code  = int'(cr[a*2 +: 2]);
      res   = c;
      delta = 0;
      if (c < 1 || c > 4) begin
        err = 1'b1;
      end else begin
        if (code == 1) delta = 1;
        else if (code == 3) delta = -1;
        else if (code == 2) err = 1'b1;
        res = ((c - 1 + delta + 4) % 4) + 1;
      end
      dst[(2-a)*4 +: 4] = 4'(res);
    end
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    entry_t e;
    cyc++;
    if (out_valid) begin
      chk("valid_while_enable", enable, 1'b1);
      chk("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bcast_data", out_data, e.d);
        chk("bcast_dst", out_dst, e.c);
        exp_cnt++;
      end
      beats_seen++;
      last_valid_cyc = cyc;
    end else begin
      chk("idle_data_zero", out_data, '0);
      chk("idle_dst_zero", out_dst, '0);
    end
    chk("particle_count", out_count, exp_cnt);
    chk("error_flag", out_error, exp_err);
    // Enable stays high for exactly one cycle after the final broadcast.
    if (rst && prev_en && !enable)
      chk("enable_tail", last_en_high_cyc, last_valid_cyc + 1);
    if (enable) last_en_high_cyc = cyc;
    // Done lands three cycles after the last cycle with enable high.
    if (out_done) begin
      done_cnt++;
      chk("done_latency", cyc - last_en_high_cyc, 3);
    end
    prev_en = rst ? enable : 1'b0;
  end

  // All drive tasks are entered and left 1 time unit after a rising edge.
  task automatic pulse_start(input bit accept);
    in_start = 1'b1;
    @(posedge clk);
    if (accept) begin
      exp_cnt = 0;
      exp_err = 1'b0;
    end
    #1;
    in_start = 1'b0;
  endtask

  task automatic send_beat(input logic [3*DW-1:0] d, input logic [11:0] src,
                           input logic [5:0] cr, input bit last);
    entry_t e;
    bit     err;
    int     n = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_src_cell = src;
    in_cross    = cr;
    in_last     = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n > 0) stall_cnt++;
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1'b1);
    end else begin
      @(posedge clk);
      model_dst(src, cr, e.c, err);
      e.d = d;
      exp_q.push_back(e);
      if (err) exp_err = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) break;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulse_once", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_after_done", out_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_t1();
    int b0;
    b0 = beats_seen;
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++)
      send_beat({32'h11 + 32'(i), 32'h22, 32'h33}, {4'd2, 4'd2, 4'd2}, 6'b0, i == 2);
    wait_done();
    chk("t1_count", out_count, 16'd3);
    chk("t1_beats", beats_seen - b0, 3);
  endtask

  initial begin
    logic [11:0] d;
    bit          e;
    logic [1:0]  codes [3];
    int          b0;
    codes = '{2'b00, 2'b01, 2'b11};

    // Hand-computed points that pin the model.
    model_dst({4'd4, 4'd1, 4'd3}, 6'b00_11_01, d, e);
    chk("model_t2a_dst", d, {4'd1, 4'd4, 4'd3});
    chk("model_t2a_err", e, 1'b0);
    model_dst({4'd1, 4'd4, 4'd1}, 6'b11_01_11, d, e);
    chk("model_t2b_dst", d, {4'd4, 4'd1, 4'd4});
    model_dst({4'd0, 4'd3, 4'd2}, 6'b00_00_10, d, e);
    chk("model_t4_dst", d, {4'd0, 4'd3, 4'd2});
    chk("model_t4_err", e, 1'b1);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_enable", enable, 1'b0);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_done", out_done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: three stay-in-place beats.
    run_t1();

    // T2: wrap on every axis in both directions.
    pulse_start(1'b1);
    send_beat({32'hA, 32'hB, 32'hC}, {4'd4, 4'd1, 4'd3}, 6'b00_11_01, 1'b0);
    send_beat({32'hD, 32'hE, 32'hF}, {4'd1, 4'd4, 4'd1}, 6'b11_01_11, 1'b1);
    wait_done();
    chk("t2_error", out_error, 1'b0);
    chk("t2_count", out_count, 16'd2);

    // T3: twenty back-to-back beats with a sink that never stalls.
    stall_cnt = 0;
    b0 = beats_seen;
    pulse_start(1'b1);
    for (int i = 0; i < 20; i++)
      send_beat({32'(i), 32'(i * 7), 32'h1000 + 32'(i)},
                {4'((i % 4) + 1), 4'(((i + 1) % 4) + 1), 4'(((i + 2) % 4) + 1)},
                {codes[(i + 2) % 3], codes[(i + 1) % 3], codes[i % 3]}, i == 19);
    wait_done();
    chk("t3_no_stall", stall_cnt, 0);
    chk("t3_count", out_count, 16'd20);
    chk("t3_beats", beats_seen - b0, 20);

    // T4: illegal code on a zero coordinate; a mid-stream start must not clear it.
    pulse_start(1'b1);
    send_beat({32'h4, 32'h4, 32'h4}, {4'd0, 4'd3, 4'd2}, 6'b00_00_10, 1'b0);
    pulse_start(1'b0);
    send_beat({32'h5, 32'h5, 32'h5}, {4'd2, 4'd2, 4'd2}, 6'b0, 1'b1);
    wait_done();
    chk("t4_error_sticky", out_error, 1'b1);
    chk("t4_count", out_count, 16'd2);

    // T5: a single-particle update; starting it clears the error.
    pulse_start(1'b1);
    chk("t5_error_cleared", out_error, 1'b0);
    chk("t5_busy", out_busy, 1'b1);
    send_beat({32'h77, 32'h66, 32'h55}, {4'd3, 4'd3, 4'd3}, 6'b01_01_01, 1'b1);
    wait_done();
    chk("t5_count", out_count, 16'd1);

    // T6: asynchronous reset mid-DRAIN, then a fresh T1.
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++)
      send_beat({32'h90 + 32'(i), 32'h0, 32'h0}, {4'd1, 4'd1, 4'd1}, 6'b0, i == 3);
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    #1;
    chk("t6_enable", enable, 1'b0);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_busy", out_busy, 1'b0);
    chk("t6_ready", in_ready, 1'b0);
    chk("t6_count", out_count, 16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    run_t1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus itself hangs.
  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d req=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
